// File: rtl/dm_access_arbiter_pkg.sv
// Shared types and constants for the data-memory access arbiter.
// Width codes, FSM encoding, default memory depth, command bundle.
package dm_pkg;

    localparam int DEFAULT_DEPTH_WORDS = 3072;

    localparam logic [1:0] WIDTH_WORD = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_BYTE = 2'b10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  width;
        logic        zext;
    } dm_cmd_t;

endpackage

// File: rtl/dm_access_arbiter_if.sv
// Requester and memory signal bundle of the data-memory arbiter.
// master = requesters plus memory model, slave = arbiter.
interface dm_access_arbiter_if #(
    parameter int ADDR_W = 12
);
    import dm_pkg::*;

    logic              a_req;
    logic              a_we;
    logic [31:0]       a_addr;
    logic [31:0]       a_wdata;
    logic [1:0]        a_width;
    logic              a_zext;
    logic              a_gnt;
    logic              a_rvalid;
    logic [31:0]       a_rdata;
    logic              a_err;

    logic              b_req;
    logic              b_we;
    logic [31:0]       b_addr;
    logic [31:0]       b_wdata;
    logic [1:0]        b_width;
    logic              b_zext;
    logic              b_gnt;
    logic              b_rvalid;
    logic [31:0]       b_rdata;
    logic              b_err;

    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output a_req, a_we, a_addr, a_wdata, a_width, a_zext,
        input  a_gnt, a_rvalid, a_rdata, a_err,
        output b_req, b_we, b_addr, b_wdata, b_width, b_zext,
        input  b_gnt, b_rvalid, b_rdata, b_err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata, a_width, a_zext,
        output a_gnt, a_rvalid, a_rdata, a_err,
        input  b_req, b_we, b_addr, b_wdata, b_width, b_zext,
        output b_gnt, b_rvalid, b_rdata, b_err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

endinterface

// File: rtl/dm_lane_fmt.sv
// Byte-lane formatting: store strobes and replicated data,
// load lane extraction with sign/zero extension, misalign flag.
module dm_lane_fmt
    import dm_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  width_i,
    input  logic        zext_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  strb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic        is_half;
    logic        is_byte;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign is_half = (width_i == WIDTH_HALF);
    assign is_byte = (width_i == WIDTH_BYTE);
    assign lane_b  = 8'(rdata_i >> {addr_lo_i, 3'b000});
    assign lane_h  = 16'(rdata_i >> {addr_lo_i[1], 4'b0000});

    // Per-width lane steering; width code 11 behaves as a word
    always_comb begin
        strb_o     = 4'b0000;
        wdata_o    = '0;
        rdata_o    = '0;
        misalign_o = 1'b0;
        unique case (1'b1)
            is_half: begin
                misalign_o = addr_lo_i[0];
                strb_o     = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{wdata_i[15:0]}};
                rdata_o    = zext_i ? {16'd0, lane_h}
                                    : {{16{lane_h[15]}}, lane_h};
            end
            is_byte: begin
                strb_o  = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = zext_i ? {24'd0, lane_b}
                                 : {{24{lane_b[7]}}, lane_b};
            end
            default: begin
                misalign_o = |addr_lo_i;
                strb_o     = 4'b1111;
                wdata_o    = wdata_i;
                rdata_o    = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/dm_access_arbiter.sv
// Round-robin arbiter sharing one single-port data memory
// between the CPU M-stage (A) and the DMA/debug loader (B).
module dm_access_arbiter
    import dm_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    dm_access_arbiter_if.slave bus
);

    logic [1:0] state_q, state_d;
    logic       prio_q, prio_d;
    logic       own_q, own_d;
    dm_cmd_t    cmd_q, cmd_d;

    dm_cmd_t     a_cmd, b_cmd;
    logic        gnt_a, gnt_b;
    logic        is_issue, is_resp;
    logic        misalign, range_err, illegal;
    logic [3:0]  strb;
    logic [31:0] wdata_sh, ld_data, rdata_v;
    logic        do_wr;

    assign a_cmd = '{we: bus.a_we, addr: bus.a_addr,
                     wdata: bus.a_wdata, width: bus.a_width,
                     zext: bus.a_zext};
    assign b_cmd = '{we: bus.b_we, addr: bus.b_addr,
                     wdata: bus.b_wdata, width: bus.b_width,
                     zext: bus.b_zext};

    // Grant only in IDLE; prio_q = 1 means B wins a tie
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (reset_ni && state_q == ST_IDLE) begin
            gnt_a = bus.a_req && (!bus.b_req || !prio_q);
            gnt_b = bus.b_req && (!bus.a_req ||  prio_q);
        end
    end

    // Sequence IDLE -> ISSUE -> RESP, capturing the winner's command
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        own_d   = own_q;
        cmd_d   = cmd_q;
        unique case (1'b1)
            (state_q == ST_IDLE): begin
                if (gnt_a || gnt_b) begin
                    own_d   = gnt_b;
                    prio_d  = gnt_a;
                    cmd_d   = gnt_b ? b_cmd : a_cmd;
                    state_d = ST_ISSUE;
                end
            end
            (state_q == ST_ISSUE): state_d = ST_RESP;
            default:               state_d = ST_IDLE;
        endcase
    end

    // State and captured command; reset drops any in-flight access
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
            own_q   <= 1'b0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            own_q   <= own_d;
            cmd_q   <= cmd_d;
        end
    end

    dm_lane_fmt u_lane_fmt (
        .addr_lo_i  (cmd_q.addr[1:0]),
        .width_i    (cmd_q.width),
        .zext_i     (cmd_q.zext),
        .wdata_i    (cmd_q.wdata),
        .rdata_i    (bus.mem_rdata),
        .strb_o     (strb),
        .wdata_o    (wdata_sh),
        .rdata_o    (ld_data),
        .misalign_o (misalign)
    );

    assign range_err = (|cmd_q.addr[31:14]) ||
                       ({20'd0, cmd_q.addr[13:2]} >= 32'(DEPTH_WORDS));
    assign illegal   = misalign || range_err;
    assign is_issue  = (state_q == ST_ISSUE);
    assign is_resp   = (state_q == ST_RESP);
    assign do_wr     = bus.mem_en && cmd_q.we;

    assign bus.a_gnt     = gnt_a;
    assign bus.b_gnt     = gnt_b;
    assign bus.mem_en    = is_issue && !illegal;
    assign bus.mem_we    = do_wr ? strb : 4'b0000;
    assign bus.mem_wdata = do_wr ? wdata_sh : '0;
    assign bus.mem_addr  = bus.mem_en ? cmd_q.addr[2 +: ADDR_W] : '0;

    assign rdata_v       = (!cmd_q.we && !illegal) ? ld_data : '0;
    assign bus.a_rvalid  = is_resp && !own_q;
    assign bus.b_rvalid  = is_resp &&  own_q;
    assign bus.a_rdata   = bus.a_rvalid ? rdata_v : '0;
    assign bus.b_rdata   = bus.b_rvalid ? rdata_v : '0;
    assign bus.a_err     = bus.a_rvalid && illegal;
    assign bus.b_err     = bus.b_rvalid && illegal;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Bench for dm_access_arbiter: directed cases then random traffic,
// checked against a byte-level memory and transaction-rule model.
module tb_dm_access_arbiter;
    import dm_pkg::*;

    typedef struct {
        bit        we;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [1:0]  width;
        bit        zext;
    } tcmd_t;

    logic clk = 1'b0;
    logic reset_ni = 1'b0;
    always #5 clk = ~clk;

    dm_access_arbiter_if bus ();

    dm_access_arbiter dut (
        .clk_i    (clk),
        .reset_ni (reset_ni),
        .bus      (bus)
    );

    logic [31:0] mem [0:3071];
    bit   [7:0]  refmem [0:12287];

    // Word memory with byte strobes and one-cycle registered read
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_addr < 12'd3072) begin
            for (int i = 0; i < 4; i++)
                if (bus.mem_we[i])
                    mem[bus.mem_addr][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    tcmd_t qa[$], qb[$];
    bit    pop_a, pop_b, rst_drv;
    int    cyc, last_gnt, gcyc;
    bit    last_a, busy, gown;
    tcmd_t gcmd;
    bit          exp_legal;
    bit   [3:0]  exp_we;
    bit   [31:0] exp_wd, exp_rd;
    int    glog_cyc[$];
    bit    glog_port[$];
    logic [31:0] obs_rd [2];
    logic        obs_err [2];
    int    n_tests, n_fail;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic int sz(bit [1:0] w);
        return (w == WIDTH_HALF) ? 2 : (w == WIDTH_BYTE) ? 1 : 4;
    endfunction

    function automatic tcmd_t mk(bit we, bit [31:0] addr,
                                 bit [31:0] wd, bit [1:0] w, bit zx);
        tcmd_t c;
        c.we = we; c.addr = addr; c.wdata = wd;
        c.width = w; c.zext = zx;
        return c;
    endfunction

    function automatic tcmd_t rnd();
        tcmd_t c;
        int    r, s;
        c.we    = 1'($urandom_range(0, 1));
        c.width = 2'($urandom_range(0, 3));
        c.zext  = 1'($urandom_range(0, 1));
        c.wdata = $urandom;
        r = $urandom_range(0, 15);
        if (r == 0)      c.addr = $urandom;
        else if (r == 1) c.addr = $urandom_range(12280, 16400);
        else             c.addr = $urandom_range(0, 12287);
        s = sz(c.width);
        if ($urandom_range(0, 3) != 0) c.addr = c.addr & ~32'(s - 1);
        return c;
    endfunction

    // Expected memory side effects and response for one access
    task automatic start_expect(input tcmd_t c);
        int s, off;
        bit [31:0] v;
        s = sz(c.width);
        off = int'(c.addr[1:0]);
        exp_legal = (c.addr % s == 0) && (c.addr < 32'd12288);
        exp_we = 4'b0000; exp_wd = '0; exp_rd = '0;
        if (exp_legal && c.we) begin
            for (int i = 0; i < 4; i++) begin
                exp_wd[8*i +: 8] = c.wdata[8*(i % s) +: 8];
                if (i >= off && i < off + s) begin
                    exp_we[i] = 1'b1;
                    refmem[int'(c.addr) - off + i] = c.wdata[8*(i % s) +: 8];
                end
            end
        end
        if (exp_legal && !c.we) begin
            v = '0;
            for (int k = 0; k < s; k++)
                v = v | (32'(refmem[int'(c.addr) + k]) << (8 * k));
            if (!c.zext && s < 4 && v[8*s-1])
                v = v | ~((32'd1 << (8 * s)) - 32'd1);
            exp_rd = v;
        end
    endtask

    task automatic drive();
        bus.a_req = (qa.size() != 0);
        if (qa.size() != 0) begin
            bus.a_we = qa[0].we; bus.a_addr = qa[0].addr;
            bus.a_wdata = qa[0].wdata; bus.a_width = qa[0].width;
            bus.a_zext = qa[0].zext;
        end else begin
            bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0;
            bus.a_width = 0; bus.a_zext = 0;
        end
        bus.b_req = (qb.size() != 0);
        if (qb.size() != 0) begin
            bus.b_we = qb[0].we; bus.b_addr = qb[0].addr;
            bus.b_wdata = qb[0].wdata; bus.b_width = qb[0].width;
            bus.b_zext = qb[0].zext;
        end else begin
            bus.b_we = 0; bus.b_addr = 0; bus.b_wdata = 0;
            bus.b_width = 0; bus.b_zext = 0;
        end
    endtask

    task automatic monitor();
        bit ra, rb, pick;
        bit [1:0] eg;
        logic [31:0] rd;
        logic        er;
        if (!reset_ni) begin
            check("rst_gnt", 64'({bus.a_gnt, bus.b_gnt}), 64'd0);
            check("rst_rv", 64'({bus.a_rvalid, bus.b_rvalid,
                                 bus.a_err, bus.b_err}), 64'd0);
            check("rst_mem", 64'({bus.mem_en, bus.mem_we,
                                  bus.mem_addr, bus.mem_wdata}), 64'd0);
            check("rst_rd", {bus.a_rdata, bus.b_rdata}, 64'd0);
            return;
        end
        ra = bus.a_req; rb = bus.b_req;
        eg = 2'b00;
        if (cyc - last_gnt >= 3 && (ra || rb)) begin
            pick = (ra && rb) ? last_a : rb;
            eg = pick ? 2'b01 : 2'b10;
        end
        check("gnt", 64'({bus.a_gnt, bus.b_gnt}), 64'(eg));
        if (eg != 2'b00) begin
            gown = pick;
            gcmd = pick ? qb[0] : qa[0];
            start_expect(gcmd);
            gcyc = cyc; busy = 1'b1; last_gnt = cyc; last_a = !pick;
            if (pick) pop_b = 1'b1; else pop_a = 1'b1;
            glog_cyc.push_back(cyc);
            glog_port.push_back(pick);
        end
        if (busy && cyc == gcyc + 1) begin
            check("mem_en", 64'(bus.mem_en), 64'(exp_legal));
            check("mem_we", 64'(bus.mem_we), 64'(exp_we));
            if (exp_legal)
                check("mem_addr", 64'(bus.mem_addr), 64'(gcmd.addr >> 2));
            if (exp_legal && gcmd.we)
                check("mem_wdata", 64'(bus.mem_wdata), 64'(exp_wd));
        end else begin
            check("idle_mem", 64'({bus.mem_en, bus.mem_we}), 64'd0);
        end
        if (busy && cyc == gcyc + 2) begin
            check("rvalid", 64'({bus.a_rvalid, bus.b_rvalid}),
                  gown ? 64'd1 : 64'd2);
            rd = gown ? bus.b_rdata : bus.a_rdata;
            er = gown ? bus.b_err : bus.a_err;
            check("rdata", 64'(rd), 64'(exp_rd));
            check("err", 64'(er), 64'(!exp_legal));
            check("other_rsp", gown ? 64'({bus.a_rdata, bus.a_err})
                                    : 64'({bus.b_rdata, bus.b_err}), 64'd0);
            obs_rd[gown] = rd;
            obs_err[gown] = er;
            busy = 1'b0;
        end else begin
            check("no_rv", 64'({bus.a_rvalid, bus.b_rvalid,
                                bus.a_err, bus.b_err}), 64'd0);
            check("no_rd", {bus.a_rdata, bus.b_rdata}, 64'd0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (pop_a) begin qa.delete(0); pop_a = 1'b0; end
        if (pop_b) begin qb.delete(0); pop_b = 1'b0; end
        if (!rst_drv) begin busy = 1'b0; last_gnt = -100; last_a = 1'b0; end
        reset_ni = rst_drv;
        drive();
        @(negedge clk);
        cyc++;
        monitor();
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0 || busy || pop_a || pop_b)
               && n < maxc) begin
            step();
            n++;
        end
        if (n >= maxc) check("drain_timeout", 64'd1, 64'd0);
    endtask

    typedef struct {
        bit [31:0] addr; bit [1:0] w; bit zx; bit [31:0] exp;
    } ld_t;
    ld_t lds[5];

    initial begin
        int k, n0;
        n_tests = 0; n_fail = 0; cyc = 0; last_gnt = -100;
        last_a = 0; busy = 0; pop_a = 0; pop_b = 0; rst_drv = 0;
        for (int i = 0; i < 3072; i++) mem[i] = '0;
        for (int i = 0; i < 12288; i++) refmem[i] = '0;
        drive();

        qa.push_back(mk(1, 32'h10, 32'h1234_80FF, WIDTH_WORD, 0));
        qb.push_back(mk(1, 32'h21, 32'h0000_00AA, WIDTH_BYTE, 0));
        repeat (3) step();
        rst_drv = 1'b1;
        step();
        check("first_gnt_a", 64'({bus.a_gnt, bus.b_gnt}), 64'd2);
        step();
        check("sw_we", 64'(bus.mem_we), 64'hF);
        check("sw_addr", 64'(bus.mem_addr), 64'd4);
        step(); step(); step();
        check("sb_we", 64'(bus.mem_we), 64'b0010);
        check("sb_wd", 64'(bus.mem_wdata), 64'hAAAA_AAAA);
        drain(50);

        lds[0] = '{32'h10, WIDTH_BYTE, 1'b0, 32'hFFFF_FFFF};
        lds[1] = '{32'h10, WIDTH_BYTE, 1'b1, 32'h0000_00FF};
        lds[2] = '{32'h10, WIDTH_HALF, 1'b0, 32'hFFFF_80FF};
        lds[3] = '{32'h10, WIDTH_HALF, 1'b1, 32'h0000_80FF};
        lds[4] = '{32'h12, WIDTH_HALF, 1'b0, 32'h0000_1234};
        foreach (lds[i]) begin
            qa.push_back(mk(0, lds[i].addr, 0, lds[i].w, lds[i].zx));
            drain(50);
            check("ld_a", 64'(obs_rd[0]), 64'(lds[i].exp));
        end
        qb.push_back(mk(0, 32'h20, 0, WIDTH_WORD, 0));
        drain(50);
        check("sb_lane", 64'(obs_rd[1]), 64'h0000_AA00);

        glog_cyc.delete(); glog_port.delete();
        for (int i = 0; i < 4; i++) begin
            qa.push_back(mk(0, 32'(4 * i), 0, WIDTH_WORD, 0));
            qb.push_back(mk(0, 32'(4 * i + 64), 0, WIDTH_WORD, 0));
        end
        drain(100);
        check("rr_count", 64'(glog_cyc.size()), 64'd8);
        for (int i = 0; i < 8 && i < glog_cyc.size(); i++) begin
            check("rr_port", 64'(glog_port[i]), 64'(i % 2));
            check("rr_cyc", 64'(glog_cyc[i] - glog_cyc[0]), 64'(3 * i));
        end

        qa.push_back(mk(0, 32'h3, 0, WIDTH_HALF, 0));
        qb.push_back(mk(0, 32'h3000, 0, WIDTH_WORD, 0));
        drain(50);
        check("err_a", 64'({obs_err[0], obs_rd[0]}), 64'h1_0000_0000);
        check("err_b", 64'({obs_err[1], obs_rd[1]}), 64'h1_0000_0000);

        qa.push_back(mk(0, 32'h10, 0, WIDTH_WORD, 0));
        n0 = glog_cyc.size(); k = 0;
        while (glog_cyc.size() == n0 && k < 20) begin step(); k++; end
        check("rst_gnt_seen", 64'(glog_cyc.size()), 64'(n0 + 1));
        rst_drv = 1'b0;
        step();
        check("rst_mid_en", 64'(bus.mem_en), 64'd0);
        repeat (2) step();
        rst_drv = 1'b1;
        qa.push_back(mk(0, 32'h10, 0, WIDTH_WORD, 0));
        drain(50);
        check("rst_reload", 64'(obs_rd[0]), 64'h1234_80FF);

        repeat (900) begin
            if (qa.size() < 2 && $urandom_range(0, 2) == 0)
                qa.push_back(rnd());
            if (qb.size() < 2 && $urandom_range(0, 2) == 0)
                qb.push_back(rnd());
            step();
        end
        drain(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/dm_access_arbiter.md
Name: dm_access_arbiter

Overview:
- Shares one single-port, word-organised data memory (3072 x 32, byte write strobes, 1-cycle registered read) between two requesters.
- Port A is the CPU M-stage load/store; port B is the DMA/debug loader.
- Arbitrates round-robin, sequences each access through a 3-state FSM, generates byte strobes and shifted write data.
- Returns sign- or zero-extended load data, and flags misaligned or out-of-range accesses without touching memory.

Parameters:
- ADDR_W, 12, word-address width driven to memory.
- DEPTH_WORDS, 3072, valid words; word index >= DEPTH_WORDS is an error.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- a_req, b_req  in  1  request; held with command fields stable until gnt.
- a_we, b_we  in  1  1 = store, 0 = load.
- a_addr, b_addr  in  32  byte address.
- a_wdata, b_wdata  in  32  store data, right-aligned.
- a_width, b_width  in  2  00 word, 01 half, 10 byte; 11 treated as word.
- a_zext, b_zext  in  1  1 = zero-extend load, 0 = sign-extend.
- a_gnt, b_gnt  out  1  one-cycle pulse; command captured this edge.
- a_rvalid, b_rvalid  out  1  one-cycle completion pulse, for loads and stores.
- a_rdata, b_rdata  out  32  extended load data; valid with rvalid, else 0.
- a_err, b_err  out  1  with rvalid: misaligned or out of range.
- mem_en  out  1  memory access strobe.
- mem_we  out  4  byte write strobes; bit i writes bits 8i+7..8i.
- mem_addr  out  ADDR_W  word address = captured addr[13:2].
- mem_wdata  out  32  lane-shifted store data.
- mem_rdata  in  32  read word, valid the cycle after mem_en.

Behaviour:
- States: IDLE, ISSUE, RESP.
- IDLE:
  - gnt is combinational; it goes to the sole requester, or to the priority holder when both request.
  - At the granting edge: capture owner, we, addr, wdata, width, zext; flip the priority pointer to the other port; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - If the captured command is legal: mem_en = 1, mem_addr from capture.
  - Store: mem_we and mem_wdata as below. Load: mem_we = 0.
  - Illegal command: mem_en = 0, mem_we = 0.
  - Always go to RESP.
- RESP:
  - Owner's rvalid = 1.
  - Load: rdata = extracted lane from mem_rdata. Store or error: rdata = 0.
  - err = 1 if illegal.
  - Always go to IDLE. Requests are ignored here; the new request is evaluated in the next IDLE.
- Throughput and latency: one access per 3 cycles. gnt at T, mem_en at T+1, rvalid at T+2.
- Illegal command, any of:
  - word with addr[1:0] != 0;
  - half with addr[0] = 1;
  - addr[31:14] != 0, or addr[13:2] >= DEPTH_WORDS.
- Store lanes:
  - word: mem_we = 1111, mem_wdata = wdata.
  - half: mem_we = 0011 if addr[1] = 0, else 1100; wdata[15:0] replicated in both halves.
  - byte: mem_we = 0001 << addr[1:0]; wdata[7:0] replicated in all four bytes.
- Load lanes:
  - byte: mem_rdata[8*addr[1:0] +: 8].
  - half: mem_rdata[16*addr[1] +: 16].
  - Extension per zext.
- Reset (asserted, async):
  - state = IDLE, priority = A, captured registers cleared.
  - All outputs 0 immediately, including mid-ISSUE/RESP.
  - An in-flight access is dropped with no rvalid; the requester re-requests.
- At most one gnt and one rvalid high in any cycle. gnt is never asserted outside IDLE.

Decomposition:
- Shared package dm_pkg:
  - width codes WIDTH_WORD = 2'b00, WIDTH_HALF = 2'b01, WIDTH_BYTE = 2'b10;
  - FSM state encoding IDLE / ISSUE / RESP;
  - DEPTH_WORDS default.
- One combinational sub-module, dm_lane_fmt:
  - inputs addr[1:0], width, zext, wdata, mem_rdata;
  - outputs byte strobes, shifted write data, extended load data, misalign flag.
- The arbiter/FSM stays in dm_access_arbiter.

Test Plan:
- Reset and hold: reset low for 3 cycles with both req = 1 -> all outputs 0, no gnt; first IDLE cycle after release -> a_gnt = 1.
- A stores word 0x1234_80FF at 0x10 -> mem_we = 1111, mem_addr = 4. Subsequent A loads from that location:
  - lb 0x10, zext = 0 -> 0xFFFF_FFFF
  - lbu 0x10 -> 0x0000_00FF
  - lh 0x10 -> 0xFFFF_80FF
  - lhu 0x10 -> 0x0000_80FF
  - lh 0x12 -> 0x0000_1234
- B sb addr 0x21, wdata 0x0000_00AA -> mem_we = 0010, mem_wdata = 0xAAAA_AAAA; following word load at 0x20 -> byte 1 = 0xAA.
- Both req held continuously -> grants A, B, A, B on cycles 0, 3, 6, 9; rvalid on 2, 5, 8, 11 to the matching port.
- A lh at 0x3, then B lw at 0x3000 -> no mem_en in either ISSUE; rvalid with err = 1, rdata = 0 for each.
- Reset pulsed low during ISSUE of an A load -> mem_en drops immediately, no a_rvalid; after release, A re-request is granted and completes normally.
